// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums a programmed number of unsigned products (from the 8x8 Wallace-tree
// multiplier Result stream) under a valid/ready handshake. The total is then
// presented on a held output handshake.
//
// Optional feature macro: PRODUCT_ACC_SAT_EN
//   defined   : Sum clamps to all-ones on the first carry out and stays there
//   undefined : Sum wraps modulo 2^ACC_W
//   Overflow is sticky for the run in both builds.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin a run (honoured only in IDLE)
//   Len        : number of products to sum, sampled with start
//   Product    : unsigned product input
//   in_valid   : Product valid
//   in_ready   : block accepts Product (state ACC)
//   Sum        : accumulated total, registered
//   out_valid  : Sum is final (state DONE)
//   out_ready  : consumer takes Sum
//   Overflow   : sticky, true sum exceeded 2^ACC_W-1 this run
//   busy       : state is not IDLE
// -----------------------------------------------------------------------------
module product_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  Len,
  input  logic [PROD_W-1:0] Product,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  Sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   sum_q,   sum_d;
  logic               ovf_q,   ovf_d;
  logic [LEN_W-1:0]   rem_q,   rem_d;

  // One extra bit so the carry out of bit ACC_W-1 is visible.
  logic [ACC_W:0]     add_w;

  assign add_w = {1'b0, sum_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, Product};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = Len;
          sum_d   = '0;
          ovf_d   = 1'b0;
          state_d = (Len != '0) ? S_ACC : S_DONE;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          rem_d = rem_q - LEN_W'(1);
          if (add_w[ACC_W]) begin
            ovf_d = 1'b1;
          end
`ifdef PRODUCT_ACC_SAT_EN
          // Once clamped, stay clamped even if a later add does not carry.
          if (ovf_q || add_w[ACC_W]) begin
            sum_d = '1;
          end else begin
            sum_d = add_w[ACC_W-1:0];
          end
`else
          sum_d = add_w[ACC_W-1:0];
`endif
          if (rem_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // Handshake flags decode from the state register only, so there is no
  // combinational path from in_valid/out_ready to any output.
  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign Sum       = sum_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  localparam int unsigned PROD_W = 16;
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  Len;
  logic [PROD_W-1:0] Product;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  Sum;
  logic              out_valid;
  logic              out_ready;
  logic              Overflow;
  logic              busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Products for the next run, consumed in order.
  int unsigned pq[$];

  product_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Len       (Len),
    .Product   (Product),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sum       (Sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Overflow  (Overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the run's final Sum/Overflow from the plain arithmetic total.
  function automatic logic [31:0] ref_sum(input longint total);
    longint maxv;
    maxv = (longint'(1) << ACC_W) - 1;
`ifdef PRODUCT_ACC_SAT_EN
    return (total > maxv) ? 32'(maxv) : 32'(total);
`else
    return 32'(total % (maxv + 1));
`endif
  endfunction

  function automatic logic [31:0] ref_ovf(input longint total);
    return (total > ((longint'(1) << ACC_W) - 1)) ? 32'd1 : 32'd0;
  endfunction

  task automatic fill_random(input int unsigned n);
    pq.delete();
    for (int i = 0; i < int'(n); i++) pq.push_back($urandom_range(0, 65535));
  endtask

  task automatic fill_const(input int unsigned n, input int unsigned v);
    pq.delete();
    for (int i = 0; i < int'(n); i++) pq.push_back(v);
  endtask

  // One complete run; length is pq.size(). Called at posedge+1.
  task automatic run(input bit inj_start, input bit early_ready,
                     input int unsigned hold, input int unsigned max_gap,
                     output logic [31:0] got_sum, output logic [31:0] got_ovf);
    int unsigned len;
    longint      total;
    logic [31:0] es, eo;
    len   = pq.size();
    total = 0;
    start     = 1'b1;
    Len       = LEN_W'(len);
    out_ready = early_ready;
    step();
    start = 1'b0;
    Len   = LEN_W'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("in_ready_after_start", 32'(in_ready), (len != 0) ? 32'd1 : 32'd0);
    check("out_valid_after_start", 32'(out_valid), (len == 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < int'(len); i++) begin
      int unsigned gaps;
      gaps = $urandom_range(0, max_gap);
      for (int g = 0; g < int'(gaps); g++) begin
        in_valid = 1'b0;
        Product  = PROD_W'($urandom);
        step();
        check("bubble_in_ready", 32'(in_ready), 32'd1);
        check("bubble_out_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      Product  = PROD_W'(pq[i]);
      if (inj_start && i == 0) begin
        start = 1'b1;
        Len   = 8'd9;
      end
      step();
      in_valid = 1'b0;
      start    = 1'b0;
      total += longint'(pq[i]);
      check("out_valid_timing", 32'(out_valid), (i == int'(len) - 1) ? 32'd1 : 32'd0);
    end
    es = ref_sum(total);
    eo = ref_ovf(total);
    check("sum", 32'(Sum), es);
    check("overflow", 32'(Overflow), eo);
    check("in_ready_done", 32'(in_ready), 32'd0);
    got_sum = 32'(Sum);
    got_ovf = 32'(Overflow);
    if (!early_ready) begin
      for (int h = 0; h < int'(hold); h++) begin
        step();
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_sum", 32'(Sum), es);
      end
      out_ready = 1'b1;
    end
    step();
    out_ready = 1'b0;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sum_kept", 32'(Sum), es);
  endtask

  initial begin
    logic [31:0] s, o;
    rst = 1'b1; start = 1'b0; Len = '0; Product = '0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_sum", 32'(Sum), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Basic back-to-back run.
    pq.delete(); pq.push_back(100); pq.push_back(200); pq.push_back(65025);
    run(1'b0, 1'b0, 0, 0, s, o);
    check("basic_sum_const", s, 32'd65325);

    // Bubbles of 3 cycles then 5 cycles of backpressure.
    pq.delete(); pq.push_back(7); pq.push_back(9);
    run(1'b0, 1'b0, 5, 3, s, o);
    check("bubble_sum_const", s, 32'd16);

    // Zero length.
    pq.delete();
    run(1'b0, 1'b0, 2, 0, s, o);
    check("zero_sum_const", s, 32'd0);

    // Overflow boundary with ACC_W=20.
    fill_const(16, 65025);
    run(1'b0, 1'b0, 0, 0, s, o);
    check("sixteen_sum_const", s, 32'd1040400);
    check("sixteen_ovf_const", o, 32'd0);
    fill_const(17, 65025);
    run(1'b0, 1'b0, 0, 1, s, o);
`ifdef PRODUCT_ACC_SAT_EN
    check("seventeen_sum_const", s, 32'd1048575);
`else
    check("seventeen_sum_const", s, 32'd56849);
`endif
    check("seventeen_ovf_const", o, 32'd1);

    // Ignored start during ACC; out_ready held high before out_valid.
    pq.delete(); pq.push_back(11); pq.push_back(22);
    run(1'b1, 1'b1, 0, 1, s, o);
    check("ignored_start_sum", s, 32'd33);

    // Reset mid-run after 1 of 4 accepts; product in reset cycle discarded.
    start = 1'b1; Len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; Product = 16'd1234;
    step();
    rst = 1'b1; Product = 16'd4321;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sum", 32'(Sum), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_ovf", 32'(Overflow), 32'd0);
    pq.delete(); pq.push_back(5);
    run(1'b0, 1'b0, 0, 0, s, o);
    check("after_rst_sum_const", s, 32'd5);

    // Randomized runs; long runs of large products exercise overflow.
    for (int r = 0; r < 25; r++) begin
      bit er;
      fill_random($urandom_range(0, 24));
      er = ($urandom_range(0, 3) == 0);
      run(1'b0, er, $urandom_range(0, 3), $urandom_range(0, 2), s, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
